// File: rtl/magphase_pkg.sv
// Shared types and lane layout for the mag/phase FM discriminator.
// Optional de-emphasis is enabled by defining MAGPHASE_DEEMPH_EN.
package magphase_pkg;

  localparam int PW_DEF = 16;
  localparam int MW_DEF = 16;

  // Lane layout is {phase, mag}; mag sits in the low bits.
  localparam int MAG_LO = 0;

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    OPEN   = 2'd1,
    HANG   = 2'd2
  } sq_state_t;

endpackage

// File: rtl/magphase_squelch_fsm.sv
// Magnitude squelch with hang time, advanced once per accepted beat.
// clear forces CLOSED, including for a beat accepted the same cycle.
module magphase_squelch_fsm
  import magphase_pkg::*;
#(
  parameter int HANG_W = 8
) (
  input  logic              ce_clk,
  input  logic              ce_rst,
  input  logic              clear,
  input  logic              adv,
  input  logic              hi,
  input  logic [HANG_W-1:0] sq_hang,
  output logic              next_closed,
  output logic              squelch_open
);

  sq_state_t         state;
  sq_state_t         cur;
  sq_state_t         nxt;
  logic [HANG_W-1:0] cnt;
  logic [HANG_W-1:0] cnt_nxt;

  // Next state for the beat being accepted this cycle.
  always_comb begin
    cur     = clear ? CLOSED : state;
    nxt     = cur;
    cnt_nxt = cnt;
    unique case (cur)
      CLOSED: begin
        if (hi) nxt = OPEN;
      end
      OPEN: begin
        if (!hi) begin
          if (sq_hang == '0) begin
            nxt = CLOSED;
          end else begin
            nxt     = HANG;
            cnt_nxt = sq_hang;
          end
        end
      end
      HANG: begin
        if (hi) begin
          nxt = OPEN;
        end else if (cnt == HANG_W'(1)) begin
          nxt = CLOSED;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: nxt = CLOSED;
    endcase
  end

  assign next_closed = (nxt == CLOSED);

  // State, hang counter and registered open flag.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state        <= CLOSED;
      cnt          <= '0;
      squelch_open <= 1'b0;
    end else if (adv) begin
      state        <= nxt;
      cnt          <= cnt_nxt;
      squelch_open <= (nxt != CLOSED);
    end else if (clear) begin
      state        <= CLOSED;
      squelch_open <= 1'b0;
    end
  end

endmodule

// File: rtl/magphase_fm_discriminator.sv
// FM discriminator: {phase,mag} in, {dphase,mag} out, squelch gated.
// Define MAGPHASE_DEEMPH_EN to add a one-pole de-emphasis IIR on dphase.
module magphase_fm_discriminator
  import magphase_pkg::*;
#(
  parameter int PW       = PW_DEF,
  parameter int MW       = MW_DEF,
  parameter int HANG_W   = 8,
  parameter int DE_SHIFT = 4
) (
  input  logic              ce_clk,
  input  logic              ce_rst,
  input  logic              clear,
  input  logic [MW-1:0]     sq_thresh,
  input  logic [HANG_W-1:0] sq_hang,
  input  logic [PW+MW-1:0]  i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [PW+MW-1:0]  o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic              squelch_open
);

  localparam int PH_LO = MAG_LO + MW;

  if (DE_SHIFT < 0 || DE_SHIFT >= PW) begin : g_bad_shift
    $error("DE_SHIFT out of range");
  end

  logic [MW-1:0]        mag;
  logic [PW-1:0]        phase;
  logic [PW-1:0]        prev_phase;
  logic                 first;
  logic                 accept;
  logic                 next_closed;
  logic [PW-1:0]        raw;
  logic signed [PW-1:0] x;
  logic [PW-1:0]        dph;

  assign mag      = i_tdata[MAG_LO +: MW];
  assign phase    = i_tdata[PH_LO +: PW];
  assign i_tready = ~o_tvalid | o_tready;
  assign accept   = i_tvalid & i_tready;

  // Wrapping difference; a cleared or first beat has no reference.
  assign raw = (first | clear) ? '0 : phase - prev_phase;
  assign x   = next_closed ? '0 : raw;

  magphase_squelch_fsm #(
    .HANG_W (HANG_W)
  ) u_sq (
    .ce_clk       (ce_clk),
    .ce_rst       (ce_rst),
    .clear        (clear),
    .adv          (accept),
    .hi           (mag >= sq_thresh),
    .sq_hang      (sq_hang),
    .next_closed  (next_closed),
    .squelch_open (squelch_open)
  );

`ifdef MAGPHASE_DEEMPH_EN
  logic signed [PW-1:0] y;
  logic signed [PW-1:0] y_cur;
  logic signed [PW-1:0] diff;
  logic signed [PW-1:0] y_nxt;

  assign y_cur = clear ? '0 : y;
  assign diff  = x - y_cur;
  assign y_nxt = y_cur + (diff >>> DE_SHIFT);
  assign dph   = y_nxt;

  // IIR state moves only with accepted beats.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      y <= '0;
    end else if (accept) begin
      y <= y_nxt;
    end else if (clear) begin
      y <= '0;
    end
  end
`else
  assign dph = x;
`endif

  // Output register, phase history and first-beat flag.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      o_tvalid   <= 1'b0;
      o_tdata    <= '0;
      o_tlast    <= 1'b0;
      prev_phase <= '0;
      first      <= 1'b1;
    end else if (accept) begin
      o_tvalid   <= 1'b1;
      o_tdata    <= {dph, mag};
      o_tlast    <= i_tlast;
      prev_phase <= phase;
      first      <= 1'b0;
    end else begin
      if (o_tready) o_tvalid <= 1'b0;
      if (clear) first <= 1'b1;
    end
  end

endmodule

// File: tb/tb_magphase_fm_discriminator.sv
// Randomized bench for magphase_fm_discriminator with a behavioural model.
// Literal vectors depend on whether MAGPHASE_DEEMPH_EN is defined.
module tb_magphase_fm_discriminator;

  localparam int DS = 2;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] sq_thresh = '0;
  logic [7:0]  sq_hang = '0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        squelch_open;

  magphase_fm_discriminator #(
    .PW       (16),
    .MW       (16),
    .HANG_W   (8),
    .DE_SHIFT (DS)
  ) dut (
    .ce_clk       (ce_clk),
    .ce_rst       (ce_rst),
    .clear        (clear),
    .sq_thresh    (sq_thresh),
    .sq_hang      (sq_hang),
    .i_tdata      (i_tdata),
    .i_tlast      (i_tlast),
    .i_tvalid     (i_tvalid),
    .i_tready     (i_tready),
    .o_tdata      (o_tdata),
    .o_tlast      (o_tlast),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready),
    .squelch_open (squelch_open)
  );

  always #5 ce_clk = ~ce_clk;

  int n_chk = 0;
  int n_pass = 0;
  bit rr_en = 1'b0;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  // Behavioural model: signal presence plus remaining hang beats.
  logic [15:0]        m_prev;
  bit                 m_first;
  bit                 m_active;
  int                 m_left;
  logic signed [15:0] m_y;
  bit                 m_sq_open;
  logic [32:0]        exp_q[$];
  logic [15:0]        log_dph[$];
  bit                 log_open[$];
  bit                 log_last[$];

  task automatic model_reset();
    m_prev = '0;
    m_first = 1'b1;
    m_active = 1'b0;
    m_left = 0;
    m_y = '0;
    m_sq_open = 1'b0;
  endtask

  task automatic model_forget();
    m_first = 1'b1;
    m_active = 1'b0;
    m_left = 0;
    m_y = '0;
    m_sq_open = 1'b0;
  endtask

  task automatic model_beat(input logic [15:0] ph, input logic [15:0] mg,
                            input logic [15:0] thr, input int hang,
                            output logic [15:0] dout);
    logic [15:0]        raw;
    logic signed [15:0] x;
    logic signed [15:0] d;
    raw = m_first ? 16'h0 : ph - m_prev;
    m_prev = ph;
    m_first = 1'b0;
    if (mg >= thr) begin
      m_active = 1'b1;
      m_left = 0;
    end else if (m_active) begin
      if (m_left == 0) begin
        if (hang == 0) m_active = 1'b0;
        else m_left = hang;
      end else if (m_left == 1) begin
        m_active = 1'b0;
        m_left = 0;
      end else begin
        m_left = m_left - 1;
      end
    end
    x = m_active ? raw : 16'h0;
`ifdef MAGPHASE_DEEMPH_EN
    d = x - m_y;
    m_y = m_y + (d >>> DS);
    dout = m_y;
`else
    d = '0;
    dout = x;
`endif
    m_sq_open = m_active;
  endtask

  // Compare process: inputs and outputs are stable at the falling edge.
  always @(negedge ce_clk) begin
    logic [32:0] e;
    logic [15:0] dv;
    if (ce_rst) begin
      model_reset();
      exp_q.delete();
    end else begin
      check("squelch_open", {31'b0, squelch_open}, {31'b0, m_sq_open});
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_beat: got 0x%0h expected none", o_tdata);
        end else begin
          e = exp_q.pop_front();
          check("o_tdata", o_tdata, e[31:0]);
          check("o_tlast", {31'b0, o_tlast}, {31'b0, e[32]});
          log_dph.push_back(o_tdata[31:16]);
          log_open.push_back(squelch_open);
          log_last.push_back(o_tlast);
        end
      end
      if (i_tvalid && i_tready) begin
        if (clear) model_forget();
        model_beat(i_tdata[31:16], i_tdata[15:0], sq_thresh, int'(sq_hang), dv);
        exp_q.push_back({i_tlast, dv, i_tdata[15:0]});
      end else if (clear) begin
        model_forget();
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge ce_clk);
      #1;
      if (rr_en) o_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [15:0] ph, input logic [15:0] mg, input bit last);
    bit ok;
    ok = 1'b0;
    i_tdata = {ph, mg};
    i_tlast = last;
    i_tvalid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge ce_clk);
      if (i_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge ce_clk);
      #1;
    end else begin
      n_chk++;
      $display("FAIL send_timeout: got no i_tready expected accept");
    end
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge ce_clk);
      #1;
      if (exp_q.size() == 0 && !o_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge ce_clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic log_reset();
    log_dph.delete();
    log_open.delete();
    log_last.delete();
  endtask

  initial begin
    logic [15:0] ph_w[4];
    logic [15:0] ex_w[4];
    logic [15:0] mg_h[5];
    logic [15:0] ex_h[5];
    bit          op_h[5];
    logic [31:0] held;
    int          nlast;

    #1 ce_rst = 1'b1;
    #1;
    check("rst_tvalid", {31'b0, o_tvalid}, 32'h0);
    check("rst_tdata", o_tdata, 32'h0);
    check("rst_tlast", {31'b0, o_tlast}, 32'h0);
    check("rst_open", {31'b0, squelch_open}, 32'h0);
    repeat (3) @(posedge ce_clk);
    #1 ce_rst = 1'b0;

    // Phase wrap across +/-pi.
    sq_thresh = 16'h0;
    sq_hang = 8'd0;
    ph_w = '{16'h1000, 16'h1400, 16'h7FF0, 16'h8010};
    ex_w = '{16'h0000, 16'h0400, 16'h6BF0, 16'h0020};
    do_clear();
    log_reset();
    for (int i = 0; i < 4; i++) send(ph_w[i], 16'h1234, i == 3);
    drain();
    check("wrap_count", log_dph.size(), 32'd4);
`ifndef MAGPHASE_DEEMPH_EN
    for (int i = 0; i < 4 && i < log_dph.size(); i++)
      check("wrap_dphase", {16'h0, log_dph[i]}, {16'h0, ex_w[i]});
`endif

`ifdef MAGPHASE_DEEMPH_EN
    ex_w = '{16'h0000, 16'h0100, 16'h01C0, 16'h0250};
    do_clear();
    log_reset();
    for (int i = 0; i < 4; i++) send(16'(i * 16'h400), 16'h0100, 1'b0);
    drain();
    check("deemph_count", log_dph.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_dph.size(); i++)
      check("deemph_dphase", {16'h0, log_dph[i]}, {16'h0, ex_w[i]});
`endif

    // Squelch hang time.
    sq_thresh = 16'h0100;
    sq_hang = 8'd2;
    mg_h = '{16'h0200, 16'h0050, 16'h0050, 16'h0050, 16'h0300};
    ex_h = '{16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0100};
    op_h = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_clear();
    log_reset();
    for (int i = 0; i < 5; i++) send(16'(i * 16'h100), mg_h[i], 1'b0);
    drain();
    check("hang_count", log_open.size(), 32'd5);
    for (int i = 0; i < 5 && i < log_open.size(); i++) begin
      check("hang_open", {31'b0, log_open[i]}, {31'b0, op_h[i]});
`ifndef MAGPHASE_DEEMPH_EN
      check("hang_dphase", {16'h0, log_dph[i]}, {16'h0, ex_h[i]});
`endif
    end

    // clear between beats of a ramp.
    sq_hang = 8'd0;
    do_clear();
    log_reset();
    send(16'h0100, 16'h0200, 1'b0);
    send(16'h0300, 16'h0200, 1'b0);
    do_clear();
    send(16'h0700, 16'h0050, 1'b1);
    drain();
    check("clr_count", log_dph.size(), 32'd3);
    if (log_dph.size() == 3) begin
`ifndef MAGPHASE_DEEMPH_EN
      check("clr_ramp", {16'h0, log_dph[1]}, 32'h0200);
`endif
      check("clr_dphase", {16'h0, log_dph[2]}, 32'h0);
      check("clr_open", {31'b0, log_open[2]}, 32'h0);
    end

    // Five-cycle stall mid-packet.
    sq_thresh = 16'h0;
    do_clear();
    log_reset();
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(i * 16'h1000), 16'(i), i == 3);
      end
      begin
        repeat (3) @(posedge ce_clk);
        #1 o_tready = 1'b0;
        @(negedge ce_clk);
        held = o_tdata;
        for (int k = 0; k < 5; k++) begin
          @(negedge ce_clk);
          check("bp_ready", {31'b0, i_tready}, 32'h0);
          check("bp_hold", o_tdata, held);
        end
        @(posedge ce_clk);
        #1 o_tready = 1'b1;
      end
    join
    drain();
    check("bp_count", log_last.size(), 32'd6);
    nlast = 0;
    foreach (log_last[i]) nlast += int'(log_last[i]);
    check("bp_nlast", nlast, 32'd1);
    if (log_last.size() == 6) begin
      check("bp_last4", {31'b0, log_last[3]}, 32'h1);
`ifndef MAGPHASE_DEEMPH_EN
      for (int i = 1; i < 6; i++)
        check("bp_dphase", {16'h0, log_dph[i]}, 32'h1000);
`endif
    end

    // Asynchronous reset with a beat held in the output register.
    o_tready = 1'b0;
    send(16'h2222, 16'h0300, 1'b0);
    #2 ce_rst = 1'b1;
    #1;
    check("arst_tvalid", {31'b0, o_tvalid}, 32'h0);
    check("arst_tdata", o_tdata, 32'h0);
    check("arst_open", {31'b0, squelch_open}, 32'h0);
    @(posedge ce_clk);
    #1 ce_rst = 1'b0;
    o_tready = 1'b1;

    // Randomized traffic with backpressure, clears and threshold changes.
    rr_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 24) == 0) do_clear();
      if ($urandom_range(0, 3) == 0) begin
        sq_thresh = 16'($urandom_range(0, 16'h300));
        sq_hang = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 4) == 0) begin
        @(posedge ce_clk);
        #1;
      end
      send(16'($urandom), 16'($urandom_range(0, 16'h400)),
           $urandom_range(0, 7) == 0);
    end
    rr_en = 1'b0;
    @(posedge ce_clk);
    #1 o_tready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
